// File: rtl/keypad_entry_unit_pkg.sv
// Shared keypad definitions: one-cold scan codes, internal key codes, FSM states
// and the key-position lookup used by the coordinate decoder.
package keypad_entry_unit_pkg;

    // One-cold codes driven by the scanner; columns and rows use the same set.
    localparam logic [3:0] ONECOLD_1 = 4'b0111;
    localparam logic [3:0] ONECOLD_2 = 4'b1011;
    localparam logic [3:0] ONECOLD_3 = 4'b1101;
    localparam logic [3:0] ONECOLD_4 = 4'b1110;

    localparam logic [3:0] KEY_BACKSPACE = 4'hE;
    localparam logic [3:0] KEY_ENTER     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_onecold(input logic [3:0] v);
        return (v == ONECOLD_1) || (v == ONECOLD_2) ||
               (v == ONECOLD_3) || (v == ONECOLD_4);
    endfunction

    function automatic logic [1:0] onecold_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            ONECOLD_2: idx = 2'd1;
            ONECOLD_3: idx = 2'd2;
            ONECOLD_4: idx = 2'd3;
            default:   idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Physical layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_BACKSPACE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_ENTER;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_unit_key_decoder.sv
// Combinational decode of a {col, row} one-cold strobe into a key class and code.
module keypad_key_decoder
    import keypad_entry_unit_pkg::*;
(
    input  logic [7:0] key_coord,
    output logic       is_event,
    output logic       is_legal,
    output logic       is_digit,
    output logic       is_alpha,
    output logic [3:0] code
);

    logic [3:0] col;
    logic [3:0] row;

    assign col      = key_coord[7:4];
    assign row      = key_coord[3:0];
    assign is_event = |key_coord;
    assign is_legal = is_event && is_onecold(col) && is_onecold(row);

    // Code is forced to 0 on illegal input so nothing downstream sees a stale key.
    assign code     = is_legal ? key_lookup(onecold_index(row), onecold_index(col)) : 4'h0;
    assign is_digit = is_legal && (code <= 4'd9);
    assign is_alpha = is_legal && (code >= 4'hA) && (code <= 4'hD);

endmodule

// File: rtl/keypad_entry_unit.sv
// Keypad number entry: edit buffer with backspace/enter, committed value handed
// to the IO controller through a valid/ack handshake.
module keypad_entry_unit
    import keypad_entry_unit_pkg::*;
#(
    parameter int MAX_DIGITS   = 8,
    parameter bit DECIMAL_ONLY = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              key_coord,
    input  logic                    input_en,
    output logic [4*MAX_DIGITS-1:0] value_out,
    output logic                    value_valid,
    input  logic                    value_ack,
    output logic [4*MAX_DIGITS-1:0] buffer_view,
    output logic [3:0]              digit_cnt,
    output logic                    key_err
);

    localparam int         W       = 4 * MAX_DIGITS;
    localparam logic [3:0] CNT_MAX = 4'(MAX_DIGITS);

    state_t         state, state_nxt;
    logic [W-1:0]   buffer_nxt, value_nxt;
    logic [3:0]     cnt_nxt;
    logic           valid_nxt, err_nxt;

    logic           is_event, is_legal, is_digit, is_alpha;
    logic [3:0]     code;
    logic           accept_nibble;

    keypad_key_decoder u_decoder (
        .key_coord (key_coord),
        .is_event  (is_event),
        .is_legal  (is_legal),
        .is_digit  (is_digit),
        .is_alpha  (is_alpha),
        .code      (code)
    );

    // Hex letters behave as ordinary digits unless the unit is decimal-only.
    assign accept_nibble = is_digit || (is_alpha && !DECIMAL_ONLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            buffer_view <= '0;
            digit_cnt   <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            buffer_view <= buffer_nxt;
            digit_cnt   <= cnt_nxt;
            value_out   <= value_nxt;
            value_valid <= valid_nxt;
            key_err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        buffer_nxt = buffer_view;
        cnt_nxt    = digit_cnt;
        value_nxt  = value_out;
        valid_nxt  = value_valid;
        err_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                buffer_nxt = '0;
                cnt_nxt    = '0;
                if (input_en) state_nxt = ST_EDIT;
            end

            ST_EDIT: begin
                // Losing input_en takes priority over any key in the same cycle.
                if (!input_en) begin
                    state_nxt  = ST_IDLE;
                    buffer_nxt = '0;
                    cnt_nxt    = '0;
                end else if (is_event) begin
                    if (!is_legal) begin
                        err_nxt = 1'b1;
                    end else if (accept_nibble) begin
                        if (digit_cnt < CNT_MAX) begin
                            buffer_nxt = {buffer_view[W-5:0], code};
                            cnt_nxt    = digit_cnt + 4'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (is_alpha) begin
                        err_nxt = 1'b1;
                    end else if (code == KEY_BACKSPACE) begin
                        if (digit_cnt != 4'd0) begin
                            buffer_nxt = buffer_view >> 4;
                            cnt_nxt    = digit_cnt - 4'd1;
                        end
                    end else if (code == KEY_ENTER) begin
                        value_nxt = buffer_view;
                        valid_nxt = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (value_ack) begin
                    valid_nxt  = 1'b0;
                    buffer_nxt = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Bench for keypad_entry_unit: hex and decimal-only instances, directed vector
// table, async reset sequence and randomized keys against a reference model.
module tb_keypad_entry_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  key_coord;
    logic        input_en;
    logic        value_ack;

    logic [31:0] value_out0, buffer_view0, value_out1, buffer_view1;
    logic        value_valid0, key_err0, value_valid1, key_err1;
    logic [3:0]  digit_cnt0, digit_cnt1;

    int total = 0;
    int bad   = 0;

    keypad_entry_unit #(.MAX_DIGITS(8), .DECIMAL_ONLY(1'b0)) dut_hex (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .input_en(input_en),
        .value_out(value_out0), .value_valid(value_valid0), .value_ack(value_ack),
        .buffer_view(buffer_view0), .digit_cnt(digit_cnt0), .key_err(key_err0)
    );

    keypad_entry_unit #(.MAX_DIGITS(8), .DECIMAL_ONLY(1'b1)) dut_dec (
        .clk(clk), .rst_n(rst_n), .key_coord(key_coord), .input_en(input_en),
        .value_out(value_out1), .value_valid(value_valid1), .value_ack(value_ack),
        .buffer_view(buffer_view1), .digit_cnt(digit_cnt1), .key_err(key_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] K0 = 8'h00, KILL = 8'h37;
    localparam logic [7:0] K1 = 8'h77, K2 = 8'hB7, K3 = 8'hD7, KA = 8'hE7;
    localparam logic [7:0] K4 = 8'h7B, K5 = 8'hBB, K6 = 8'hDB;
    localparam logic [7:0] K7 = 8'h7D, K8 = 8'hBD, K9 = 8'hDD;
    localparam logic [7:0] KS = 8'h7E, KH = 8'hDE;

    // Reference model: mode 0=idle 1=edit 2=done; buffer kept as a plain number.
    int      m_mode[2];
    longint  m_buf[2];
    int      m_cnt[2];
    longint  m_val[2];
    bit      m_vld[2];
    bit      m_err[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_buf[d] = 0; m_cnt[d] = 0;
            m_val[d] = 0; m_vld[d] = 0; m_err[d] = 0;
        end
    endfunction

    function automatic void decode(input logic [7:0] c, output bit legal, output byte ch);
        string keys;
        int ci, ri;
        keys  = "123A456B789C*0#D";
        legal = ($countones(~c[7:4]) == 1) && ($countones(~c[3:0]) == 1);
        ci = 0; ri = 0;
        for (int i = 0; i < 4; i++) begin
            if (!c[7-i]) ci = i;
            if (!c[3-i]) ri = i;
        end
        ch = legal ? keys[ri*4+ci] : 8'h00;
    endfunction

    function automatic void model_step(input int d, input logic [7:0] c,
                                       input logic en, input logic ack);
        bit  legal;
        byte ch;
        bit  is_dig, is_alp;
        int  nib;
        m_err[d] = 0;
        case (m_mode[d])
            0: begin
                m_buf[d] = 0; m_cnt[d] = 0;
                if (en) m_mode[d] = 1;
            end
            1: begin
                if (!en) begin
                    m_mode[d] = 0; m_buf[d] = 0; m_cnt[d] = 0;
                end else if (c != 8'h00) begin
                    decode(c, legal, ch);
                    is_dig = (ch >= "0") && (ch <= "9");
                    is_alp = (ch >= "A") && (ch <= "D");
                    nib    = is_dig ? (ch - "0") : (ch - "A" + 10);
                    if (!legal) m_err[d] = 1;
                    else if (is_dig || (is_alp && d == 0)) begin
                        if (m_cnt[d] < 8) begin
                            m_buf[d] = m_buf[d] * 16 + nib;
                            m_cnt[d]++;
                        end else m_err[d] = 1;
                    end else if (is_alp) m_err[d] = 1;
                    else if (ch == "*") begin
                        if (m_cnt[d] > 0) begin
                            m_buf[d] = m_buf[d] / 16;
                            m_cnt[d]--;
                        end
                    end else if (ch == "#") begin
                        m_val[d] = m_buf[d]; m_vld[d] = 1; m_mode[d] = 2;
                    end
                end
            end
            default: begin
                if (ack) begin
                    m_vld[d] = 0; m_buf[d] = 0; m_cnt[d] = 0; m_mode[d] = 0;
                end
            end
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("hex.value_out",   value_out0,          32'(m_val[0]));
        cmp("hex.value_valid", 32'(value_valid0),   32'(m_vld[0]));
        cmp("hex.buffer_view", buffer_view0,        32'(m_buf[0]));
        cmp("hex.digit_cnt",   32'(digit_cnt0),     32'(m_cnt[0]));
        cmp("hex.key_err",     32'(key_err0),       32'(m_err[0]));
        cmp("dec.value_out",   value_out1,          32'(m_val[1]));
        cmp("dec.value_valid", 32'(value_valid1),   32'(m_vld[1]));
        cmp("dec.buffer_view", buffer_view1,        32'(m_buf[1]));
        cmp("dec.digit_cnt",   32'(digit_cnt1),     32'(m_cnt[1]));
        cmp("dec.key_err",     32'(key_err1),       32'(m_err[1]));
    endtask

    // Drive one cycle of inputs from a falling edge, sample at the next falling edge.
    task automatic step(input logic [7:0] c, input logic en, input logic ack);
        key_coord = c; input_en = en; value_ack = ack;
        model_step(0, c, en, ack);
        model_step(1, c, en, ack);
        @(posedge clk);
        @(negedge clk);
        key_coord = 8'h00; value_ack = 1'b0;
        check_model();
    endtask

    typedef struct {
        logic [7:0]  coord;
        logic        en;
        logic        ack;
        logic [31:0] val;
        logic        vld;
        logic [31:0] buff;
        logic [3:0]  cnt;
        logic        err;
        logic        err1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] c, input logic en, input logic ack,
                                input logic [31:0] val, input logic vld,
                                input logic [31:0] buff, input logic [3:0] cnt,
                                input logic err, input logic err1);
        vec_t v;
        v.coord = c; v.en = en; v.ack = ack; v.val = val; v.vld = vld;
        v.buff = buff; v.cnt = cnt; v.err = err; v.err1 = err1;
        return v;
    endfunction

    initial begin
        logic [7:0] run_keys [9];
        logic [31:0] run_buf;
        run_keys = '{K1, K2, K3, K4, K5, K6, K7, K8, K9};

        // Entry 1,2,3,# then ack; DONE ignores keys and input_en.
        tbl.push_back(mk(K0, 1, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K1, 1, 0, 32'h0,   0, 32'h1,   1, 0, 0));
        tbl.push_back(mk(K2, 1, 0, 32'h0,   0, 32'h12,  2, 0, 0));
        tbl.push_back(mk(K3, 1, 0, 32'h0,   0, 32'h123, 3, 0, 0));
        tbl.push_back(mk(KH, 1, 0, 32'h123, 1, 32'h123, 3, 0, 0));
        tbl.push_back(mk(K5, 1, 0, 32'h123, 1, 32'h123, 3, 0, 0));
        tbl.push_back(mk(K0, 0, 0, 32'h123, 1, 32'h123, 3, 0, 0));
        tbl.push_back(mk(K0, 0, 1, 32'h123, 0, 32'h0,   0, 0, 0));
        // Ack while not valid has no effect; 4,5,*,6,#.
        tbl.push_back(mk(K0, 1, 1, 32'h123, 0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K4, 1, 0, 32'h123, 0, 32'h4,   1, 0, 0));
        tbl.push_back(mk(K5, 1, 0, 32'h123, 0, 32'h45,  2, 0, 0));
        tbl.push_back(mk(KS, 1, 0, 32'h123, 0, 32'h4,   1, 0, 0));
        tbl.push_back(mk(K6, 1, 0, 32'h123, 0, 32'h46,  2, 0, 0));
        tbl.push_back(mk(KH, 1, 0, 32'h46,  1, 32'h46,  2, 0, 0));
        // Ack together with a key: key discarded.
        tbl.push_back(mk(K7, 1, 1, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(KS, 1, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(KS, 1, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(KILL, 1, 0, 32'h46, 0, 32'h0,  0, 1, 1));
        tbl.push_back(mk(KA, 1, 0, 32'h46,  0, 32'hA,   1, 0, 1));
        tbl.push_back(mk(KS, 1, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        run_buf = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) run_buf = (run_buf << 4) | 32'(i + 1);
            tbl.push_back(mk(run_keys[i], 1, 0, 32'h46, 0, run_buf,
                             (i < 8) ? 4'(i + 1) : 4'd8, i == 8, i == 8));
        end
        tbl.push_back(mk(K0, 1, 0, 32'h46,  0, 32'h12345678, 8, 0, 0));
        // input_en drop wins over a simultaneous key; IDLE ignores keys.
        tbl.push_back(mk(K7, 0, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K8, 0, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K0, 1, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K7, 1, 0, 32'h46,  0, 32'h7,   1, 0, 0));
        tbl.push_back(mk(K8, 1, 0, 32'h46,  0, 32'h78,  2, 0, 0));
        tbl.push_back(mk(K0, 0, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K1, 0, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        // Commit 9, then keys and illegal codes in DONE are silent.
        tbl.push_back(mk(K0, 1, 0, 32'h46,  0, 32'h0,   0, 0, 0));
        tbl.push_back(mk(K9, 1, 0, 32'h46,  0, 32'h9,   1, 0, 0));
        tbl.push_back(mk(KH, 1, 0, 32'h9,   1, 32'h9,   1, 0, 0));
        tbl.push_back(mk(K2, 1, 0, 32'h9,   1, 32'h9,   1, 0, 0));
        tbl.push_back(mk(KILL, 1, 0, 32'h9, 1, 32'h9,   1, 0, 0));
        tbl.push_back(mk(K0, 0, 0, 32'h9,   1, 32'h9,   1, 0, 0));

        rst_n = 1'b0; key_coord = 8'h00; input_en = 1'b0; value_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].coord, tbl[i].en, tbl[i].ack);
            cmp($sformatf("tbl[%0d].value_out", i),   value_out0,        tbl[i].val);
            cmp($sformatf("tbl[%0d].value_valid", i), 32'(value_valid0), 32'(tbl[i].vld));
            cmp($sformatf("tbl[%0d].buffer_view", i), buffer_view0,      tbl[i].buff);
            cmp($sformatf("tbl[%0d].digit_cnt", i),   32'(digit_cnt0),   32'(tbl[i].cnt));
            cmp($sformatf("tbl[%0d].key_err", i),     32'(key_err0),     32'(tbl[i].err));
            cmp($sformatf("tbl[%0d].dec_key_err", i), 32'(key_err1),     32'(tbl[i].err1));
        end

        // Async reset while DONE holds 0x9: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp("rst_async.value_valid", 32'(value_valid0), 32'h0);
        cmp("rst_async.value_out",   value_out0,        32'h0);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(K5, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] c;
            int r;
            r = $urandom_range(0, 99);
            if (r < 30)      c = 8'h00;
            else if (r < 90) c = {~(4'b0001 << $urandom_range(0, 3)), ~(4'b0001 << $urandom_range(0, 3))};
            else             c = 8'($urandom_range(1, 255));
            step(c, $urandom_range(0, 99) < 95, $urandom_range(0, 99) < 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
